// File: rtl/ddr_if_pkg.sv
// ----------------------------------------------------------------------------
// ddr_if_pkg
// Shared definitions for blocks that talk to the MIG user (app) interface.
//   MIG_CMD_READ / MIG_CMD_WRITE : app_cmd encodings
//   ERR_REQ_DROPPED              : err_sticky bit, loader strobed while ddr_en==0
//   ERR_DATA_UNEXP               : err_sticky bit, read beat arrived with no read in flight
// ----------------------------------------------------------------------------
package ddr_if_pkg;

    localparam logic [2:0] MIG_CMD_READ  = 3'b001;
    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;

    localparam int ERR_REQ_DROPPED = 0;
    localparam int ERR_DATA_UNEXP  = 1;

endpackage

// File: rtl/ddr_weights_read_adapter_if.sv
// ----------------------------------------------------------------------------
// ddr_weights_read_adapter_if
// Bundles the loader-side request/return signals, the MIG app read signals and
// the adapter status outputs.
//   modport slave  : the adapter's view
//   modport master : the environment's view (loader + MIG + monitor)
// Handshake rules:
//   loader -> adapter : request taken when weights_word_ddr_en_rd && ddr_en;
//                       ddr_en depends on registered state only.
//   adapter -> MIG    : command taken when app_en && app_rdy; app_en/app_addr
//                       stay stable until taken.
//   MIG -> adapter    : app_rd_data_valid has no backpressure.
//   adapter -> loader : valid_load_weights has no backpressure.
// ----------------------------------------------------------------------------
interface ddr_weights_read_adapter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 512
);
    logic              weights_word_ddr_en_rd;
    logic [31:0]       weights_word_ddr_adr_rd;
    logic              ddr_en;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] app_rd_data;
    logic              valid_load_weights;
    logic [DATA_W-1:0] load_weights_data;
    logic [7:0]        outstanding;
    logic              rd_idle;
    logic [1:0]        err_sticky;

    modport slave (
        input  weights_word_ddr_en_rd, weights_word_ddr_adr_rd,
        input  app_rdy, app_rd_data_valid, app_rd_data,
        output ddr_en, app_en, app_cmd, app_addr,
        output valid_load_weights, load_weights_data,
        output outstanding, rd_idle, err_sticky
    );

    modport master (
        output weights_word_ddr_en_rd, weights_word_ddr_adr_rd,
        output app_rdy, app_rd_data_valid, app_rd_data,
        input  ddr_en, app_en, app_cmd, app_addr,
        input  valid_load_weights, load_weights_data,
        input  outstanding, rd_idle, err_sticky
    );
endinterface

// File: rtl/ddr_weights_read_adapter_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers and show-ahead head output.
//   clk, reset : clock, synchronous active-high reset (flushes pointers)
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop head entry (ignored when empty)
//   o_data     : current head entry
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
// Push and pop in the same cycle are both honoured when not full/empty.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/ddr_weights_read_adapter.sv
// ----------------------------------------------------------------------------
// ddr_weights_read_adapter
// Turns the weights loader's word-address read strobes into MIG app READ
// commands and hands the returned words back to the loader/weight buffer.
//   clk, reset : MIG ui_clk, synchronous active-high reset
//   bus        : loader request/return, MIG app read side and status
//                (see ddr_weights_read_adapter_if)
// Requests are queued in a small FIFO; a credit counter caps reads in flight
// so that ddr_en is an exact accept-ready for the loader.
// ----------------------------------------------------------------------------
module ddr_weights_read_adapter
    import ddr_if_pkg::*;
#(
    parameter int ADDR_W          = 28,
    parameter int DATA_W          = 512,
    parameter int WORD_SHIFT      = 3,
    parameter int REQ_FIFO_DEPTH  = 4,
    parameter int MAX_OUTSTANDING = 32
) (
    input logic                      clk,
    input logic                      reset,
    ddr_weights_read_adapter_if.slave bus
);
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ADDR_W-1:0] w_fifo_head;
    logic [ADDR_W-1:0] w_push_addr;
    logic              w_ddr_en;
    logic              w_accept;
    logic              w_app_en;
    logic              w_pop;
    logic              w_ret_dec;
    logic              w_unused_adr_hi;

    logic [7:0]        r_outstanding;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_err;

    // Word address to MIG column address; bits that would shift past
    // ADDR_W are dropped.
    assign w_push_addr     = {bus.weights_word_ddr_adr_rd[ADDR_W-WORD_SHIFT-1:0],
                              {WORD_SHIFT{1'b0}}};
    assign w_unused_adr_hi = ^bus.weights_word_ddr_adr_rd[31:ADDR_W-WORD_SHIFT];

    // Accept-ready never looks at the strobe, so the loader can use it
    // combinationally without creating a loop.
    assign w_ddr_en  = !reset && !w_fifo_full &&
                       (r_outstanding < 8'(MAX_OUTSTANDING));
    assign w_accept  = bus.weights_word_ddr_en_rd && w_ddr_en;
    assign w_app_en  = !reset && !w_fifo_empty;
    assign w_pop     = w_app_en && bus.app_rdy;
    // A beat with nothing in flight is forwarded but must not underflow.
    assign w_ret_dec = bus.app_rd_data_valid && (r_outstanding != 8'd0);

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  (w_push_addr),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= 8'd0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_err         <= 2'b00;
        end else begin
            r_valid <= bus.app_rd_data_valid;
            if (bus.app_rd_data_valid) r_data <= bus.app_rd_data;

            case ({w_accept, w_ret_dec})
                2'b10:   r_outstanding <= r_outstanding + 8'd1;
                2'b01:   r_outstanding <= r_outstanding - 8'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (bus.weights_word_ddr_en_rd && !w_ddr_en)
                r_err[ERR_REQ_DROPPED] <= 1'b1;
            if (bus.app_rd_data_valid && (r_outstanding == 8'd0))
                r_err[ERR_DATA_UNEXP] <= 1'b1;
        end
    end

    assign bus.ddr_en             = w_ddr_en;
    assign bus.app_en             = w_app_en;
    assign bus.app_cmd            = MIG_CMD_READ;
    assign bus.app_addr           = w_fifo_head;
    assign bus.valid_load_weights = r_valid;
    assign bus.load_weights_data  = r_data;
    assign bus.outstanding        = r_outstanding;
    assign bus.rd_idle            = w_fifo_empty && (r_outstanding == 8'd0);
    assign bus.err_sticky         = r_err;
endmodule
